// File: rtl/spi_client_sync.sv
// spi_client_sync: SPI client oversampled in the system clock domain.
// SCLK, CS_n and MOSI are synchronised, edges are detected on the synchronised
// SCLK/CS_n, and rx/tx words are exchanged over ready/valid streams.
// Build option: define SPI_CLIENT_SYNC_LSB_FIRST_EN to shift LSB-first in both
// directions; the default build shifts MSB-first.
module spi_client_sync #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_spi_clk,
    input  logic             i_spi_cs_n,
    input  logic             i_mosi,
    output logic             o_miso,
    output logic             o_active,
    output logic             o_rx_valid,
    input  logic             i_rx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_first,
    output logic             o_rx_overrun,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    input  logic [WIDTH-1:0] i_tx_data,
    output logic             o_tx_underrun
);

    localparam int unsigned CW        = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic        SCLK_IDLE = (CPOL != 0);

    // Synchroniser chains and a fill marker that tracks when the chain output
    // reflects a genuine pin sample rather than the reset value.
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;

    logic sclk_lvl_q, cs_lvl_q, mosi_q;
    logic sclk_rise_q, sclk_fall_q, cs_fall_q;
    logic armed_q, active_q;

    logic sclk_s, cs_s, mosi_s, armed_d;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign armed_d = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);

    // Pin synchronisers, registered edge pulses and arming state.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_lvl_q  <= SCLK_IDLE;
            cs_lvl_q    <= 1'b1;
            mosi_q      <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            armed_q     <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_spi_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_lvl_q  <= sclk_s;
            cs_lvl_q    <= cs_s;
            mosi_q      <= mosi_s;
            sclk_rise_q <= sclk_s & ~sclk_lvl_q;
            sclk_fall_q <= ~sclk_s & sclk_lvl_q;
            cs_fall_q   <= ~cs_s & cs_lvl_q;
            armed_q     <= armed_d;
            active_q    <= armed_d & ~cs_s;
        end
    end

    // Datapath state
    logic [CW-1:0]    rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d, tx_buf_q, tx_buf_d;
    logic             rx_valid_q, rx_valid_d, rx_first_q, rx_first_d;
    logic             rx_overrun_q, rx_overrun_d, tx_underrun_q, tx_underrun_d;
    logic             first_q, first_d, tx_full_q, tx_full_d;
    logic             tx_ready_q, tx_ready_d, miso_q, miso_d;

    logic             lead_c, trail_c, sample_c, drive_c, rx_accept_c;
    logic [WIDTH-1:0] rx_next_c, tx_load_c;

    assign lead_c      = (CPOL != 0) ? sclk_fall_q : sclk_rise_q;
    assign trail_c     = (CPOL != 0) ? sclk_rise_q : sclk_fall_q;
    assign sample_c    = active_q & ((CPHA != 0) ? trail_c : lead_c);
    assign drive_c     = active_q & (((CPHA != 0) ? lead_c : trail_c)
                                     | ((CPHA == 0) & cs_fall_q));
    assign rx_accept_c = rx_valid_q & i_rx_ready;

    // Next-state logic for rx assembly, tx shifting and the holding buffer.
    always_comb begin
        rx_cnt_d      = rx_cnt_q;
        tx_cnt_d      = tx_cnt_q;
        rx_sh_d       = rx_sh_q;
        tx_sh_d       = tx_sh_q;
        rx_data_d     = rx_data_q;
        tx_buf_d      = tx_buf_q;
        rx_valid_d    = rx_valid_q;
        rx_first_d    = rx_first_q;
        rx_overrun_d  = 1'b0;
        tx_underrun_d = 1'b0;
        first_d       = first_q;
        tx_full_d     = tx_full_q;
        miso_d        = miso_q;
`ifdef SPI_CLIENT_SYNC_LSB_FIRST_EN
        rx_next_c     = {mosi_q, rx_sh_q[WIDTH-1:1]};
`else
        rx_next_c     = {rx_sh_q[WIDTH-2:0], mosi_q};
`endif
        tx_load_c     = '0;

        if (rx_accept_c) begin
            rx_valid_d = 1'b0;
        end

        if (!active_q) begin
            // Deasserted CS: drop partial words, next word is a frame start.
            rx_cnt_d = '0;
            tx_cnt_d = '0;
            first_d  = 1'b1;
        end else begin
            if (sample_c) begin
                rx_sh_d = rx_next_c;
                if (rx_cnt_q == CW'(WIDTH - 1)) begin
                    rx_cnt_d = '0;
                    if (!rx_valid_q || rx_accept_c) begin
                        rx_data_d  = rx_next_c;
                        rx_valid_d = 1'b1;
                        rx_first_d = first_q;
                        first_d    = 1'b0;
                    end else begin
                        rx_overrun_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end

            if (drive_c) begin
                if (tx_cnt_q == '0) begin
                    if (tx_full_q) begin
                        tx_load_c = tx_buf_q;
                        tx_full_d = 1'b0;
                    end else begin
                        tx_underrun_d = 1'b1;
                    end
                    tx_sh_d = tx_load_c;
`ifdef SPI_CLIENT_SYNC_LSB_FIRST_EN
                    miso_d  = tx_load_c[0];
`else
                    miso_d  = tx_load_c[WIDTH-1];
`endif
                end else begin
`ifdef SPI_CLIENT_SYNC_LSB_FIRST_EN
                    tx_sh_d = {1'b0, tx_sh_q[WIDTH-1:1]};
                    miso_d  = tx_sh_q[1];
`else
                    tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
                    miso_d  = tx_sh_q[WIDTH-2];
`endif
                end
                tx_cnt_d = (tx_cnt_q == CW'(WIDTH - 1)) ? '0 : tx_cnt_q + CW'(1);
            end
        end

        // Buffer write is only accepted while empty, so it never races a load.
        if (i_tx_valid && tx_ready_q) begin
            tx_buf_d  = i_tx_data;
            tx_full_d = 1'b1;
        end
        tx_ready_d = ~tx_full_d;
    end

    // Datapath registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rx_cnt_q      <= '0;
            tx_cnt_q      <= '0;
            rx_sh_q       <= '0;
            tx_sh_q       <= '0;
            rx_data_q     <= '0;
            tx_buf_q      <= '0;
            rx_valid_q    <= 1'b0;
            rx_first_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            first_q       <= 1'b1;
            tx_full_q     <= 1'b0;
            tx_ready_q    <= 1'b1;
            miso_q        <= 1'b0;
        end else begin
            rx_cnt_q      <= rx_cnt_d;
            tx_cnt_q      <= tx_cnt_d;
            rx_sh_q       <= rx_sh_d;
            tx_sh_q       <= tx_sh_d;
            rx_data_q     <= rx_data_d;
            tx_buf_q      <= tx_buf_d;
            rx_valid_q    <= rx_valid_d;
            rx_first_q    <= rx_first_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
            first_q       <= first_d;
            tx_full_q     <= tx_full_d;
            tx_ready_q    <= tx_ready_d;
            miso_q        <= miso_d;
        end
    end

    assign o_miso        = miso_q;
    assign o_active      = active_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_rx_data     = rx_data_q;
    assign o_rx_first    = rx_first_q;
    assign o_rx_overrun  = rx_overrun_q;
    assign o_tx_ready    = tx_ready_q;
    assign o_tx_underrun = tx_underrun_q;

endmodule
